// File: rtl/pc_fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_if
//   Bundles every non-clock/reset signal of the fetch sequencer.
//   master : the sequencer itself (drives PC, memory request, decode outputs)
//   slave  : the surrounding system (PC calc unit, instruction memory, decode)
//
//   PC calc  : pc_out -> ; <- pc_plus4, branch_pc, jmp_pc
//   Memory   : imem_req, imem_addr -> ; <- imem_ack, imem_rdata
//   Decode   : inst_valid, inst_out, inst_pc -> ;
//              <- inst_ready, take_branch, take_jump, halt
//   Status   : halted, fault, retire_cnt ->
// ---------------------------------------------------------------------------
interface pc_fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pc_out;
    logic [31:0]      pc_plus4;
    logic [31:0]      branch_pc;
    logic [31:0]      jmp_pc;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             inst_valid;
    logic [31:0]      inst_out;
    logic [31:0]      inst_pc;
    logic             inst_ready;
    logic             take_branch;
    logic             take_jump;
    logic             halt;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output pc_out, imem_req, imem_addr, inst_valid, inst_out, inst_pc,
               halted, fault, retire_cnt,
        input  pc_plus4, branch_pc, jmp_pc, imem_ack, imem_rdata,
               inst_ready, take_branch, take_jump, halt
    );

    modport slave (
        input  pc_out, imem_req, imem_addr, inst_valid, inst_out, inst_pc,
               halted, fault, retire_cnt,
        output pc_plus4, branch_pc, jmp_pc, imem_ack, imem_rdata,
               inst_ready, take_branch, take_jump, halt
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//   Multi-cycle fetch controller owning the architectural PC. Each instruction
//   takes a REQ phase (memory req/ack) and a HOLD phase (decode valid/ready).
//   On the decode handshake the next PC is chosen (jump > branch > PC+4),
//   unless the instruction is a halt or the chosen PC is misaligned, in which
//   case the sequencer parks in HALTED until reset.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : pc_fetch_sequencer_if.master (PC calc, imem, decode, status)
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pc_fetch_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [31:0]      pc;
    logic [31:0]      inst_word;
    logic [31:0]      inst_addr;
    logic             halted_q;
    logic             fault_q;
    logic [CNT_W-1:0] retire_q;

    logic             ack_taken;
    logic             handshake;
    logic [31:0]      next_pc;
    logic             next_misaligned;

    // ack is only meaningful while a request is outstanding; stray acks
    // arriving in any other state are dropped here.
    assign ack_taken = (state == REQ) && bus.imem_ack;
    assign handshake = (state == HOLD) && bus.inst_ready;

    always_comb begin
        if (bus.take_jump) begin
            next_pc = bus.jmp_pc;
        end else if (bus.take_branch) begin
            next_pc = bus.branch_pc;
        end else begin
            next_pc = bus.pc_plus4;
        end
    end

    assign next_misaligned = (next_pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    // halt wins over the flags; a bad target also stops fetch
                    if (bus.halt || next_misaligned) begin
                        state_next = HALTED;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: handshake strobes depend on state only, never on inputs
    always_comb begin
        bus.imem_req   = 1'b0;
        bus.inst_valid = 1'b0;
        case (state)
            REQ:     bus.imem_req   = 1'b1;
            HOLD:    bus.inst_valid = 1'b1;
            default: begin
                bus.imem_req   = 1'b0;
                bus.inst_valid = 1'b0;
            end
        endcase
    end

    // PC, captured instruction and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            inst_word <= 32'h0;
            inst_addr <= 32'h0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            retire_q  <= '0;
        end else begin
            if (ack_taken) begin
                inst_word <= bus.imem_rdata;
                inst_addr <= pc;
            end
            if (handshake) begin
                retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (bus.halt) begin
                    halted_q <= 1'b1;
                end else if (next_misaligned) begin
                    halted_q <= 1'b1;
                    fault_q  <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

    // imem_addr tracks the PC register directly so it is stable across a
    // whole REQ phase and equals RESET_PC while in reset.
    assign bus.pc_out     = pc;
    assign bus.imem_addr  = pc;
    assign bus.inst_out   = inst_word;
    assign bus.inst_pc    = inst_addr;
    assign bus.halted     = halted_q;
    assign bus.fault      = fault_q;
    assign bus.retire_cnt = retire_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Multi-cycle fetch controller that owns the architectural PC register and sequences the PC calculation datapath.
- Drives the current PC to the PC adder/target unit and receives back PC+4, branch target and jump target.
- Issues instruction-memory requests over a req/ack handshake and presents fetched instructions to decode over a valid/ready handshake.
- Selects the next PC from the decode-side branch/jump flags. Also provides halt, alignment-fault and retire-count functions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_out  output  32  current PC; feeds oldPC of the PC calculation unit.
- pc_plus4  input  32  pc_out+4 from the PC calculation unit.
- branch_pc  input  32  branch target from the PC calculation unit.
- jmp_pc  input  32  jump target from the PC calculation unit.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  request address.
- imem_ack  input  1  memory has data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  inst_out/inst_pc valid to decode.
- inst_out  output  32  held instruction word.
- inst_pc  output  32  PC of inst_out.
- inst_ready  input  1  decode accepts the instruction.
- take_branch  input  1  accepted instruction is a taken branch.
- take_jump  input  1  accepted instruction is a jump.
- halt  input  1  accepted instruction is a halt.
- halted  output  1  sequencer stopped.
- fault  output  1  misaligned next PC detected.
- retire_cnt  output  CNT_W  number of accepted instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately at any point, including mid-request):
  - State = IDLE; pc_out = RESET_PC.
  - imem_req = 0, imem_addr = RESET_PC.
  - inst_valid = 0, inst_out = 0, inst_pc = 0.
  - halted = 0, fault = 0, retire_cnt = 0.
  - Any in-flight imem_ack after reset is ignored unless the sequencer is in REQ.
- States: IDLE, REQ, HOLD, HALTED.
- IDLE:
  - Outputs quiet for one cycle after reset deassertion.
  - Unconditional transition to REQ.
- REQ:
  - imem_req = 1 and imem_addr = pc_out; both are stable until ack.
  - imem_ack may arrive in the first REQ cycle (zero-wait memory) or any later cycle.
  - On the ack cycle: register imem_rdata into inst_out and pc_out into inst_pc, then go to HOLD.
  - imem_req drops in the cycle after ack.
- HOLD:
  - inst_valid = 1; inst_out and inst_pc are held stable.
  - take_branch, take_jump and halt are sampled only when inst_valid && inst_ready.
  - On the handshake cycle:
    - retire_cnt increments, wrapping modulo 2^CNT_W.
    - Next PC selection has priority: jump (jmp_pc) > branch (branch_pc) > pc_plus4. If take_jump and take_branch are both high, jmp_pc is used.
    - If halt is high: go to HALTED; pc_out is unchanged; the branch/jump flags are ignored.
    - Else, if the selected next PC has [1:0] != 0: fault = 1, go to HALTED, pc_out unchanged.
    - Else: pc_out = selected next PC, go to REQ.
  - inst_valid drops in the cycle after the handshake.
  - Without inst_ready, the sequencer stays in HOLD indefinitely.
- HALTED:
  - imem_req = 0, inst_valid = 0, halted = 1; fault is sticky.
  - Exit only by reset.
- Throughput: minimum 2 cycles per instruction (REQ with immediate ack, then HOLD with immediate ready).
- PC wrap: the sequencer loads whatever the PC calculation unit returns. Example: pc_plus4 of 0xFFFFFFFC wraps to 0x00000000 and is accepted without fault.
- Outputs are registered except imem_req, imem_addr and inst_valid, which are decoded from state and registers, with no combinational path from inputs.

Test Plan:
- Reset release, zero-wait memory, inst_ready always 1 -> imem_addr sequence 0x0, 0x4, 0x8; new inst_valid every 2 cycles; retire_cnt = 3 after the third handshake.
- imem_ack delayed 3 cycles at PC 0x10 -> imem_req high for 4 cycles with imem_addr = 0x10 held; inst_out = imem_rdata from the ack cycle.
- HOLD with take_jump = 1, take_branch = 1, jmp_pc = 0x400, branch_pc = 0x80 -> next imem_addr = 0x400.
- inst_ready held low 5 cycles, then take_branch = 1 with branch_pc = 0x24 -> inst_valid high all 6 cycles; retire_cnt increments once; next imem_addr = 0x24.
- Handshake with jmp_pc = 0x402 and take_jump = 1 -> fault = 1, halted = 1, pc_out unchanged, imem_req stays 0. Same case with halt = 1 -> halted = 1, fault = 0.
- rst_n pulsed low mid-REQ at PC 0x40 -> pc_out = RESET_PC immediately and imem_req = 0 asynchronously; after release, fetch restarts at RESET_PC; retire_cnt = 0.
